regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default `WORD (64): register and data width in bits.
REQ-002 Parameter DEPTH, default 32: number of architectural registers.
REQ-003 Parameter NUM_READ, default 2: number of read ports, legal range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register DEPTH-1 is XZR (hardwired zero).
REQ-005 Derived constant AW = clog2(DEPTH): width of every address field.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rd_addr  input  NUM_READ*AW  read addresses, port p at bits [p*AW +: AW].
REQ-009 rd_data  output  NUM_READ*WIDTH  registered read data, port p at bits [p*WIDTH +: WIDTH].
REQ-010 rd_busy  output  NUM_READ  registered busy flag of the addressed register, one per port.
REQ-011 wr_en  input  1  write enable.
REQ-012 wr_addr  input  AW  write address.
REQ-013 wr_data  input  WIDTH  write data.
REQ-014 rsv_en  input  1  reserve request; marks the register as busy (pending producer).
REQ-015 rsv_addr  input  AW  register to reserve.

Function
REQ-016 Read latency SHALL be exactly 1 cycle: rd_addr sampled at edge N, rd_data and rd_busy valid after edge N until edge N+1.
REQ-017 Write SHALL update reg[wr_addr] <= wr_data at a rising edge when wr_en=1; no effect when wr_en=0.
REQ-018 wr_en=1 SHALL clear busy[wr_addr] at the same edge.
REQ-019 rsv_en=1 SHALL set busy[rsv_addr] at the edge; reserving an already-busy register leaves it busy.
REQ-020 rsv_en and wr_en to the same register in the same cycle: data SHALL be written and busy SHALL end set (the new reservation wins).
REQ-021 With ZERO_REG=1, XZR reads SHALL return 0 with rd_busy=0; writes and reservations to XZR SHALL be ignored.
REQ-022 Addresses >= DEPTH (non-power-of-2 DEPTH) SHALL read 0, not busy; writes and reservations to them SHALL be ignored.
REQ-023 Multiple ports addressing the same register in one cycle SHALL each return identical data and busy.
REQ-024 Read of wr_addr in the same cycle as its write: behaviour per REQ-029/REQ-030.

Reset
REQ-025 rst_n=0 SHALL, without waiting for clk, set reg[i] to RESET_VALUES[i] for every i, clear all busy bits, and drive rd_data=0 and rd_busy=0.
REQ-026 Assertion mid-write or mid-reservation SHALL discard that operation; the first edge after deassertion performs normal reads and writes.
REQ-027 XZR SHALL read 0 regardless of its RESET_VALUES entry.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN selects same-cycle write forwarding.
REQ-029 Defined: a read port whose rd_addr equals wr_addr with wr_en=1 SHALL return wr_data and the post-edge busy state (REQ-018/REQ-020 applied).
REQ-030 Undefined: that port SHALL return the pre-write register value and the pre-edge busy state; the new value is visible one cycle later.

Structure
REQ-031 Package regfile_pkg SHALL hold WORD, the RESET_VALUES array (entry 0=256, 3=16, 5=4, 12=17, 15=129, 19=10, all others 0) and the address-width helper.
REQ-032 Sub-module regfile_read_port (address decode, XZR/out-of-range masking, bypass mux, output register) SHALL be instantiated NUM_READ times by generate.
REQ-033 Storage and the busy vector SHALL reside in regfile_mp only.

Verification
REQ-034 Reset, then read addresses 0 and 5 -> rd_data 256 and 4 after one edge; rd_busy=00.
REQ-035 Write 55 to register 0, reading 0 and 12 in the same cycle -> with bypass 55/17 at the next edge; without bypass 256/17, then 55/17 one cycle later.
REQ-036 Reserve register 15; next cycle read 15 on both ports -> rd_busy=11; write -354 to 15 -> busy clears, both ports read -354.
REQ-037 Same-cycle rsv_en and wr_en to register 7 with data 9 -> register 7 reads 9 and remains busy.
REQ-038 Write 23456 to register 31 (ZERO_REG=1) and reserve it -> reads 0, rd_busy=0; wr_en=0 with changed wr_data -> no register changes.
REQ-039 Assert rst_n mid-cycle after writes -> outputs 0 immediately; after release, register 15 reads 129.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: data word width,
// per-register reset values and the address-width helper.
package regfile_pkg;

   localparam int unsigned WORD             = 64;
   localparam int unsigned NUM_RESET_VALUES = 32;

   localparam logic [WORD-1:0] RESET_VALUES [NUM_RESET_VALUES] = '{
      0       : 64'd256,
      3       : 64'd16,
      5       : 64'd4,
      12      : 64'd17,
      15      : 64'd129,
      19      : 64'd10,
      default : 64'd0
   };

   // Registers beyond the table reset to zero.
   function automatic logic [WORD-1:0] reset_value(input int unsigned idx);
      logic [WORD-1:0] val;
      val = '0;
      if (idx < NUM_RESET_VALUES) val = RESET_VALUES[idx[4:0]];
      return val;
   endfunction

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_mp_read_port.sv
// One registered read port: address decode, XZR/out-of-range masking and,
// when REGFILE_BYPASS_EN is defined, same-cycle write forwarding.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = WORD,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned AW       = addr_width(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [AW-1:0]               rd_addr,
   input  logic [DEPTH-1:0][WIDTH-1:0] reg_q,
   input  logic [DEPTH-1:0]            busy_q,
   input  logic [DEPTH-1:0]            busy_next,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        rd_busy
);

   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] XZR     = AW'(DEPTH - 1);

   logic             readable;
   logic [WIDTH-1:0] data_d;
   logic             busy_d;

   assign readable = ({1'b0, rd_addr} < DEPTH_X) &&
                     !((ZERO_REG != 0) && (rd_addr == XZR));

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      data_d = '0;
      busy_d = 1'b0;
      if (readable) begin
         // A matching write can only target a writable register, so the
         // post-edge busy bit already reflects clear-then-reserve ordering.
         if (wr_en && (wr_addr == rd_addr)) begin
            data_d = wr_data;
            busy_d = busy_next[rd_addr];
         end else begin
            data_d = reg_q[rd_addr];
            busy_d = busy_q[rd_addr];
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{wr_en, wr_addr, wr_data, busy_next};

   always_comb begin
      data_d = '0;
      busy_d = 1'b0;
      if (readable) begin
         data_d = reg_q[rd_addr];
         busy_d = busy_q[rd_addr];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_busy <= 1'b0;
      end else begin
         rd_data <= data_d;
         rd_busy <= busy_d;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy (reservation) bits.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int unsigned WIDTH    = WORD,
   parameter  int unsigned DEPTH    = 32,
   parameter  int unsigned NUM_READ = 2,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = addr_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_READ*AW-1:0]    rd_addr,
   output logic [NUM_READ*WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]       rd_busy,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rsv_en,
   input  logic [AW-1:0]             rsv_addr
);

   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] XZR     = AW'(DEPTH - 1);

   logic [DEPTH-1:0][WIDTH-1:0] reg_q;
   logic [DEPTH-1:0]            busy_q;
   logic [DEPTH-1:0]            busy_next;
   logic                        wr_ok;
   logic                        rsv_ok;

   function automatic logic writable(input logic [AW-1:0] addr);
      return ({1'b0, addr} < DEPTH_X) && !((ZERO_REG != 0) && (addr == XZR));
   endfunction

   assign wr_ok  = wr_en  && writable(wr_addr);
   assign rsv_ok = rsv_en && writable(rsv_addr);

   // Reservation applied after the write-clear so a same-register pair stays busy.
   always_comb begin
      busy_next = busy_q;
      if (wr_ok)  busy_next[wr_addr]  = 1'b0;
      if (rsv_ok) busy_next[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            reg_q[i] <= WIDTH'(reset_value(i));
         end
         busy_q <= '0;
      end else begin
         if (wr_ok) reg_q[wr_addr] <= wr_data;
         busy_q <= busy_next;
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      regfile_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .AW       (AW)
      ) u_port (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_addr   (rd_addr[p*AW +: AW]),
         .reg_q     (reg_q),
         .busy_q    (busy_q),
         .busy_next (busy_next),
         .wr_en     (wr_ok),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .rd_data   (rd_data[p*WIDTH +: WIDTH]),
         .rd_busy   (rd_busy[p])
      );
   end

endmodule
